// File: rtl/btn_debounce_pulse_if.sv
// Button conditioner signal bundle: raw button toward the conditioner, clean level and strobes back.
// The slave modport is the conditioner; the master modport is whoever owns the button and uses the strobes.
interface btn_debounce_pulse_if;
    logic btn_raw;
    logic btn_level;
    logic btn_pulse;
    logic btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-FF synchroniser, stability-counter debounce, registered level and strobes.
// Define AUTO_REPEAT_EN to add hold-to-repeat press strobes (REPEAT_DELAY, then every REPEAT_PERIOD).
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_debounce_pulse_if.slave  btn
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        PRESSED = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             btn_s;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] hold_inc;
    logic             first_q, first_d;
`endif

    assign btn_s = sync2_q;

    // Saturating increment: a stuck-high input can never wrap the counter back into range.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        sync1_d   = btn.btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;

        // The entry cycle counts as the first stable sample, so a change is accepted on the
        // cycle the incremented count reaches DEBOUNCE_CYCLES-1 (DEBOUNCE_CYCLES stable samples).
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_inc == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

`ifdef AUTO_REPEAT_EN
        hold_inc = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_ONE;
        hold_d   = hold_q;
        first_d  = first_q;
        // Leaving to IDLE wins over a repeat due in the same cycle, so the release strobe stays alone.
        if (state_d == IDLE) begin
            hold_d  = '0;
            first_d = 1'b1;
        end else if (state_q == WAIT_HI && state_d == PRESSED) begin
            hold_d  = '0;
            first_d = 1'b1;
        end else if (state_q == PRESSED || state_q == WAIT_LO) begin
            hold_d = hold_inc;
            if (hold_inc == (first_q ? RPT_FIRST : RPT_NEXT)) begin
                pulse_d = 1'b1;
                hold_d  = '0;
                first_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            hold_q    <= '0;
            first_q   <= 1'b1;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
`ifdef AUTO_REPEAT_EN
            hold_q    <= hold_d;
            first_q   <= first_d;
`endif
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_pulse   = pulse_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus random bounce, checked every cycle against a
// windowed-stability reference model (a level flips once the last DEBOUNCE_CYCLES synced samples all differ).
module tb_btn_debounce_pulse;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_pulse_if bif ();

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bif)
    );

    int   tests = 0;
    int   fails = 0;
    int   edge_k = 0;
    int   press_k = 0;
    int   pulse_cnt = 0;
    int   rel_cnt = 0;
    int   last_pulse_k = 0;
    int   last_rel_k = 0;
    logic hist [0:DB+1];
    logic m_level = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DB + 1; i++) hist[i] = 1'b0;
        m_level = 1'b0;
    endtask

    // One clock with btn_raw held at v; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v);
        bit all_diff;
        bit exp_pulse;
        bit exp_rel;
        int d;
        bif.btn_raw = v;
        @(posedge clk);
        #1;
        edge_k++;
        for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        // hist[2] is what the logic sees this edge, after two synchroniser stages.
        all_diff = 1'b1;
        for (int i = 2; i < 2 + DB; i++) if (hist[i] == m_level) all_diff = 1'b0;
        exp_pulse = 1'b0;
        exp_rel   = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            if (m_level) begin
                exp_pulse = 1'b1;
                press_k   = edge_k;
            end else begin
                exp_rel = 1'b1;
            end
        end else if (AUTO && m_level) begin
            d = edge_k - press_k;
            if (d >= RD && ((d - RD) % RP) == 0) exp_pulse = 1'b1;
        end
        chk("level", int'(bif.btn_level), int'(m_level));
        chk("pulse", int'(bif.btn_pulse), int'(exp_pulse));
        chk("release", int'(bif.btn_release), int'(exp_rel));
        chk("one_strobe", int'(bif.btn_pulse & bif.btn_release), 0);
        if (bif.btn_pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse_k = edge_k;
        end
        if (bif.btn_release === 1'b1) begin
            rel_cnt++;
            last_rel_k = edge_k;
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_level"}, int'(bif.btn_level), 0);
        chk({tag, "_pulse"}, int'(bif.btn_pulse), 0);
        chk({tag, "_release"}, int'(bif.btn_release), 0);
    endtask

    initial begin
        int t0;
        int p0;
        int r0;
        logic v;
        int len;

        // Test 1: reset held with button pressed, release, first press 6 clk later.
        bif.btn_raw = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk_outputs_zero("rst_hold");
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("rst_hold_clk");
        rst_n = 1'b1;
        t0 = edge_k;
        pulse_cnt = 0;
        hold(1'b1, 10);
        chk("t1_pulses", pulse_cnt, 1);
        chk("t1_latency", last_pulse_k - t0, DB + 2);
        chk("t1_level", int'(bif.btn_level), 1);

        // Test 2: clean release, then clean press held 20 clk.
        hold(1'b0, 12);
        chk("t2_idle", int'(bif.btn_level), 0);
        t0 = edge_k;
        pulse_cnt = 0;
        hold(1'b1, 20);
        chk("t2_pulses", pulse_cnt, 1);
        chk("t2_latency", last_pulse_k - t0, DB + 2);
        chk("t2_level", int'(bif.btn_level), 1);
        hold(1'b0, 12);

        // Test 3: bounce every 2 clk for 20 clk, then settle low.
        pulse_cnt = 0;
        rel_cnt = 0;
        for (int i = 0; i < 10; i++) hold(i[0] ? 1'b0 : 1'b1, 2);
        hold(1'b0, 10);
        chk("t3_pulses", pulse_cnt, 0);
        chk("t3_releases", rel_cnt, 0);
        chk("t3_level", int'(bif.btn_level), 0);

        // Test 4: short dropout while pressed is ignored; clean release later.
        hold(1'b1, 12);
        rel_cnt = 0;
        hold(1'b0, 3);
        hold(1'b1, 10);
        chk("t4_dropout_rel", rel_cnt, 0);
        chk("t4_level_held", int'(bif.btn_level), 1);
        t0 = edge_k;
        hold(1'b0, 12);
        chk("t4_releases", rel_cnt, 1);
        chk("t4_rel_latency", last_rel_k - t0, DB + 2);

        // Test 5: async reset while qualifying a press (count at 2), then re-qualify from zero.
        hold(1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs_zero("t5_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = edge_k;
        pulse_cnt = 0;
        hold(1'b1, 10);
        chk("t5_pulses", pulse_cnt, 1);
        chk("t5_latency", last_pulse_k - t0, DB + 2);
        hold(1'b0, 12);

        // Test 6: long hold of 60 clk.
        pulse_cnt = 0;
        rel_cnt = 0;
        p0 = edge_k;
        hold(1'b1, 60);
        hold(1'b0, 15);
        chk("t6_pulses", pulse_cnt, AUTO ? 6 : 1);
        chk("t6_releases", rel_cnt, 1);
        r0 = p0;
        chk("t6_final_level", int'(bif.btn_level), 0);

        // Random bounce segments, every cycle checked against the model.
        for (int s = 0; s < 60; s++) begin
            v   = 1'($urandom_range(0, 1));
            len = (s % 5 == 4) ? int'($urandom_range(DB + 2, DB + 30)) : int'($urandom_range(1, DB + 3));
            hold(v, len);
        end
        hold(1'b0, 12);
        chk("end_level", int'(bif.btn_level), 0);
        if (r0 < 0) $display("unused %0d", r0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
